// File: rtl/cardinal_nic.sv
// -----------------------------------------------------------------------------
// cardinal_nic
//
// Single-entry network interface between a processor register port and a
// router port. One input buffer (router -> processor) and one output buffer
// (processor -> router), each with a full flag. The two paths run fully
// independently of each other.
//
// Bit numbering: the packet format numbers bit 0 as the MSB. Vectors here are
// declared [DATA_WIDTH-1:0], so packet bit 0 is physical bit DATA_WIDTH-1, and
// a status flag "in bit DATA_WIDTH-1" sits in the physical LSB.
//
// Ports
//   clk           sole clock, all state updates on posedge
//   reset         synchronous, active-high reset
//   addr[1:0]     register select: 00 IB, 01 IB status, 10 OB, 11 OB status
//   d_in          processor store data
//   d_out         processor load data (combinational)
//   nicEn         processor access enable
//   nicWrEn       processor write enable (0 = read)
//   net_si        router -> NIC send request
//   net_ri        NIC -> router ready (input buffer empty)
//   net_di        router -> NIC packet
//   net_so        NIC -> router send strobe
//   net_ro        router ready to accept a packet
//   net_do        NIC -> router packet (always the output buffer)
//   net_polarity  router virtual-channel phase, toggles every cycle
// -----------------------------------------------------------------------------
module cardinal_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  // Packet bit 0 (MSB-first numbering) carries the virtual-channel bit.
  localparam int VC_BIT = DATA_WIDTH - 1;

  localparam logic [1:0] ADDR_IB      = 2'b00;
  localparam logic [1:0] ADDR_IB_STAT = 2'b01;
  localparam logic [1:0] ADDR_OB      = 2'b10;
  localparam logic [1:0] ADDR_OB_STAT = 2'b11;

  logic [DATA_WIDTH-1:0] r_ib;
  logic [DATA_WIDTH-1:0] r_ob;
  logic                  r_in_full;
  logic                  r_out_full;

  logic w_rd;
  logic w_wr;
  logic w_ib_pop;
  logic w_ib_push;
  logic w_ob_load;
  logic w_so;

  assign w_rd = nicEn & ~nicWrEn;
  assign w_wr = nicEn &  nicWrEn;

  // A pop and a push can never coincide: a push needs in_full=0, a pop needs 1.
  assign w_ib_pop  = w_rd & (addr == ADDR_IB) & r_in_full;
  assign w_ib_push = net_si & ~r_in_full;

  // Load is judged on out_full at cycle start, so a store arriving during the
  // send cycle is dropped rather than queued behind the departing packet.
  assign w_ob_load = w_wr & (addr == ADDR_OB) & ~r_out_full;
  assign w_so      = r_out_full & net_ro & (r_ob[VC_BIT] == net_polarity);

  assign net_ri = ~r_in_full;
  assign net_so = w_so;
  assign net_do = r_ob;

  always_comb begin
    // NOTE: default assigned first so every path through the case drives
    // d_out; without it a missing arm would infer a latch.
    d_out = '0;
    if (w_rd) begin
      unique case (addr)
        ADDR_IB:      d_out = r_ib;
        ADDR_IB_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
        ADDR_OB_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, r_out_full};
        ADDR_OB:      d_out = '0;
        default:      d_out = '0;
      endcase
    end
  end

  // Input path: router fills, processor read of addr 00 drains.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the buffers are cleared as well as the flags so a stale packet
      // can never be read back after reset.
      r_in_full <= 1'b0;
      r_ib      <= '0;
    end else if (w_ib_pop) begin
      r_in_full <= 1'b0;
    end else if (w_ib_push) begin
      r_ib      <= net_di;
      r_in_full <= 1'b1;
    end
  end

  // Output path: processor store to addr 10 fills, send strobe drains. The
  // drained packet stays in r_ob (net_do keeps showing it) but is invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_full <= 1'b0;
      r_ob       <= '0;
    end else if (w_ob_load) begin
      r_ob       <= d_in;
      r_out_full <= 1'b1;
    end else if (w_so) begin
      r_out_full <= 1'b0;
    end
  end

endmodule
